// File: rtl/uart_ctrl_if.sv
// Memory-mapped bus between the MEM stage and the UART controller.
// The master drives the strobes, address and store data; the slave returns load data.
interface uart_ctrl_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_ctrl.sv
// Memory-mapped 8N1 UART with independent TX/RX engines and a status/control register.
// TXD, RXD and CON live at fixed word addresses.
module uart_ctrl #(
  parameter int BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        reset,
  uart_ctrl_if.slave  bus,
  input  logic        uart_rx,
  output logic        uart_tx,
  input  logic        supervisor,
  output logic        irq
);

  localparam logic [31:0] ADDR_TXD  = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD  = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON  = 32'h4000_0020;
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic txd_wr, con_wr, rxd_rd, con_rd;
  assign txd_wr = bus.wr && (bus.addr == ADDR_TXD);
  assign con_wr = bus.wr && (bus.addr == ADDR_CON);
  assign rxd_rd = bus.rd && (bus.addr == ADDR_RXD);
  assign con_rd = bus.rd && (bus.addr == ADDR_CON);

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:8];

  // ---------------- transmitter ----------------
  state_t      tx_state_reg, tx_state_next;
  logic [15:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]  tx_bit_reg, tx_bit_next;
  logic [7:0]  tx_shift_reg, tx_shift_next;
  logic        uart_tx_reg, tx_line;
  logic        tx_busy_reg, tx_done_reg;
  logic        tx_accept, tx_finish;

  // The line register lags the state by one cycle, so every bit keeps its full width
  // and busy drops one cycle after STOP ends, exactly ten bit times after the fall.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_line       = 1'b1;
    tx_accept     = 1'b0;
    tx_finish     = 1'b0;
    case (tx_state_reg)
      IDLE: begin
        tx_finish = tx_busy_reg;
        if (txd_wr && !tx_busy_reg) begin
          tx_accept     = 1'b1;
          tx_shift_next = bus.wdata[7:0];
          tx_state_next = START;
          tx_cnt_next   = 16'd0;
          tx_bit_next   = 3'd0;
        end
      end
      START: begin
        tx_line = 1'b0;
        if (tx_cnt_reg == BIT_LAST) begin
          tx_state_next = DATA;
          tx_cnt_next   = 16'd0;
        end else begin
          tx_cnt_next = tx_cnt_reg + 16'd1;
        end
      end
      DATA: begin
        tx_line = tx_shift_reg[0];
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = 16'd0;
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          if (tx_bit_reg == 3'd7) tx_state_next = STOP;
          else                    tx_bit_next   = tx_bit_reg + 3'd1;
        end else begin
          tx_cnt_next = tx_cnt_reg + 16'd1;
        end
      end
      STOP: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_state_next = IDLE;
          tx_cnt_next   = 16'd0;
        end else begin
          tx_cnt_next = tx_cnt_reg + 16'd1;
        end
      end
      default: tx_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_reg <= IDLE;
      tx_cnt_reg   <= 16'd0;
      tx_bit_reg   <= 3'd0;
      tx_shift_reg <= 8'd0;
      uart_tx_reg  <= 1'b1;
      tx_busy_reg  <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      uart_tx_reg  <= tx_line;
      if (tx_accept)      tx_busy_reg <= 1'b1;
      else if (tx_finish) tx_busy_reg <= 1'b0;
    end
  end

  assign uart_tx = uart_tx_reg;

  // ---------------- receiver ----------------
  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
  state_t      rx_state_reg, rx_state_next;
  logic [15:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]  rx_bit_reg, rx_bit_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic [7:0]  rx_data_reg;
  logic        rx_ready_reg, ovr_reg, ferr_reg;
  logic        rx_good, rx_bad;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_good       = 1'b0;
    rx_bad        = 1'b0;
    case (rx_state_reg)
      IDLE: begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_state_next = START;
          rx_cnt_next   = 16'd0;
        end
      end
      START: begin
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next = 16'd0;
          rx_bit_next = 3'd0;
          rx_state_next = rx_sync_reg ? IDLE : DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + 16'd1;
        end
      end
      DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = 16'd0;
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
          if (rx_bit_reg == 3'd7) rx_state_next = STOP;
          else                    rx_bit_next   = rx_bit_reg + 3'd1;
        end else begin
          rx_cnt_next = rx_cnt_reg + 16'd1;
        end
      end
      STOP: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_state_next = IDLE;
          rx_cnt_next   = 16'd0;
          rx_good       = rx_sync_reg;
          rx_bad        = !rx_sync_reg;
        end else begin
          rx_cnt_next = rx_cnt_reg + 16'd1;
        end
      end
      default: rx_state_next = IDLE;
    endcase
  end

  // Synchronizer and edge history reset to the idle-high line level so release never looks like a start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= IDLE;
      rx_cnt_reg   <= 16'd0;
      rx_bit_reg   <= 3'd0;
      rx_shift_reg <= 8'd0;
    end else begin
      rx_meta_reg  <= uart_rx;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  // ---------------- status / control ----------------
  logic tx_ie_reg, rx_ie_reg;

  // Setting events take priority over read-side clears on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_reg  <= 8'd0;
      rx_ready_reg <= 1'b0;
      ovr_reg      <= 1'b0;
      ferr_reg     <= 1'b0;
      tx_done_reg  <= 1'b0;
      tx_ie_reg    <= 1'b0;
      rx_ie_reg    <= 1'b0;
    end else begin
      if (rx_good) begin
        rx_data_reg  <= rx_shift_reg;
        rx_ready_reg <= 1'b1;
      end else if (rxd_rd) begin
        rx_ready_reg <= 1'b0;
      end
      if (rx_good && rx_ready_reg && !rxd_rd) ovr_reg <= 1'b1;
      else if (con_rd)                        ovr_reg <= 1'b0;
      if (rx_bad)      ferr_reg <= 1'b1;
      else if (con_rd) ferr_reg <= 1'b0;
      if (tx_finish)   tx_done_reg <= 1'b1;
      else if (con_rd) tx_done_reg <= 1'b0;
      if (con_wr) begin
        tx_ie_reg <= bus.wdata[0];
        rx_ie_reg <= bus.wdata[1];
      end
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (bus.rd) begin
      case (bus.addr)
        ADDR_RXD: bus.rdata = {24'd0, rx_data_reg};
        ADDR_CON: bus.rdata = {25'd0, ferr_reg, ovr_reg, tx_busy_reg, tx_done_reg,
                               rx_ready_reg, rx_ie_reg, tx_ie_reg};
        default:  bus.rdata = 32'd0;
      endcase
    end
  end

  assign irq = ~supervisor & ((tx_ie_reg & tx_done_reg) | (rx_ie_reg & rx_ready_reg));

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl at BAUD_DIV=4: TX/RX byte scoreboards, CON flag behaviour, irq and reset.
module tb_uart_ctrl;
  localparam int BD = 4;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic supervisor = 1'b0;
  logic uart_tx, irq;

  uart_ctrl_if bus();

  uart_ctrl #(.BAUD_DIV(BD)) dut (
    .clk(clk), .reset(reset), .bus(bus), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .supervisor(supervisor), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] rx_last = 8'h00;

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.rd = 1'b1; bus.addr = a;
    #1 d = bus.rdata;
    @(negedge clk);
    bus.rd = 1'b0; bus.addr = 32'd0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.wr = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
  endtask

  // Drives one 8N1 frame; only frames with a good stop bit are expected to land in RXD.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BD) @(negedge clk);
    end
    uart_rx = stop_bit;
    if (stop_bit) rx_exp.push_back(b);
    repeat (BD) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  // TX monitor: decodes frames on uart_tx mid-bit and scores them against tx_exp.
  initial begin
    logic prev, stop_v, ab;
    logic [7:0] mb, e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset && prev && uart_tx === 1'b0) begin
        ab = 1'b0;
        repeat (BD/2) @(negedge clk);
        if (!reset) ab = 1'b1;
        for (int j = 0; j < 8; j++) begin
          repeat (BD) @(negedge clk);
          if (!reset) ab = 1'b1;
          mb[j] = uart_tx;
        end
        repeat (BD) @(negedge clk);
        if (!reset) ab = 1'b1;
        stop_v = uart_tx;
        if (!ab) begin
          total++;
          if (tx_exp.size() == 0) begin
            bad++;
            $display("FAIL tx_unexpected_frame: got %02h stop=%b, expected no frame", mb, stop_v);
          end else begin
            e = tx_exp.pop_front();
            if (mb !== e || stop_v !== 1'b1) begin
              bad++;
              $display("FAIL tx_frame: got %02h stop=%b, expected %02h stop=1", mb, stop_v, e);
            end else begin
              $display("tx frame %02h ok", mb);
            end
          end
        end
      end
      prev = uart_tx;
    end
  end

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    bus.rd = 1'b1; bus.addr = A_CON;
    #1;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
    d = bus.rdata;
    total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_con: got %08h expected 0", d); end
    @(negedge clk);
    bus.rd = 1'b0; bus.addr = 32'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset: con=%08h tx=%b irq=%b", d, uart_tx, irq);
  endtask

  task automatic test_tx();
    logic [31:0] d;
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    bus_write(A_CON, 32'h1);
    tx_exp.push_back(8'hA5);
    bus_write(A_TXD, 32'h0000_00A5);
    for (int i = 0; i < 10*BD; i++) begin
      @(negedge clk);
      bus.wr = 1'b0; bus.rd = 1'b0;
      if (i == 2*BD) begin bus.wr = 1'b1; bus.addr = A_TXD; bus.wdata = 32'h11; end
      if (i == 5*BD) begin bus.rd = 1'b1; bus.addr = A_CON; end
      #1;
      total++;
      if (uart_tx !== frame[i/BD]) begin
        bad++; $display("FAIL tx_bit[%0d]: got %b expected %b", i, uart_tx, frame[i/BD]);
      end
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL tx_irq_early[%0d]: got %b expected 0", i, irq); end
      if (i == 5*BD) begin
        d = bus.rdata;
        total++;
        if (d !== 32'h11) begin bad++; $display("FAIL tx_busy_con: got %08h expected 00000011", d); end
      end
    end
    @(negedge clk);
    bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = 32'd0;
    #1;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL tx_done_irq: got %b expected 1", irq); end
    bus_read(A_CON, d);
    total++; if (d !== 32'h09) begin bad++; $display("FAIL tx_done_con: got %08h expected 00000009", d); end
    bus_read(A_CON, d);
    total++; if (d !== 32'h01) begin bad++; $display("FAIL tx_done_clear: got %08h expected 00000001", d); end
    for (int i = 0; i < 12*BD; i++) begin
      @(negedge clk);
      if (i == 0 || i == 12*BD-1) begin
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL tx_idle_after[%0d]: got %b expected 1", i, uart_tx); end
      end
    end
    $display("tx: A5 frame sent, 0x11 write during frame discarded, con=%08h", d);
  endtask

  task automatic test_rx();
    logic [31:0] d;
    bus_write(A_CON, 32'h2);
    send_frame(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rx_irq: got %b expected 1", irq); end
    bus.addr = A_CON;
    #1;
    total++; if (bus.rdata !== 32'd0) begin bad++; $display("FAIL rdata_idle: got %08h expected 0", bus.rdata); end
    bus_read(32'h4000_0024, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL unmapped_read: got %08h expected 0", d); end
    bus_read(A_CON, d);
    total++; if (d !== 32'h06) begin bad++; $display("FAIL rx_con: got %08h expected 00000006", d); end
    bus_read(A_RXD, d);
    rx_last = rx_exp.pop_front();
    total++; if (d !== {24'd0, rx_last}) begin bad++; $display("FAIL rx_data: got %08h expected %08h", d, {24'd0, rx_last}); end
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rx_irq_clear: got %b expected 0", irq); end
    $display("rx: byte %02h read, irq=%b", d[7:0], irq);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0] e;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(A_CON, d);
    total++; if (d !== 32'h26) begin bad++; $display("FAIL ovr_con: got %08h expected 00000026", d); end
    bus_read(A_RXD, d);
    rx_last = rx_exp[$];
    rx_exp.delete();
    total++; if (d !== {24'd0, rx_last}) begin bad++; $display("FAIL ovr_data: got %08h expected %08h", d, {24'd0, rx_last}); end
    bus_read(A_CON, d);
    total++; if (d !== 32'h02) begin bad++; $display("FAIL ovr_clear: got %08h expected 00000002", d); end
    $display("back_to_back: overrun flagged and cleared, rxd=%02h", rx_last);
    // A byte completing on the same edge as an RXD read keeps rx_ready and does not overrun.
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    bus.rd = 1'b1; bus.addr = A_RXD;
    #1 d = bus.rdata;
    e = rx_exp.pop_front();
    total++; if (d !== {24'd0, e}) begin bad++; $display("FAIL same_edge_old: got %08h expected %08h", d, {24'd0, e}); end
    @(negedge clk);
    bus.rd = 1'b0; bus.addr = 32'd0;
    bus_read(A_CON, d);
    total++; if (d !== 32'h06) begin bad++; $display("FAIL same_edge_con: got %08h expected 00000006", d); end
    bus_read(A_RXD, d);
    rx_last = rx_exp.pop_front();
    total++; if (d !== {24'd0, rx_last}) begin bad++; $display("FAIL same_edge_new: got %08h expected %08h", d, {24'd0, rx_last}); end
    $display("same_edge: rxd=%02h", d[7:0]);
  endtask

  task automatic test_errors();
    logic [31:0] d;
    send_frame(8'h5A, 1'b0);
    repeat (2) @(negedge clk);
    bus_read(A_CON, d);
    total++; if (d !== 32'h42) begin bad++; $display("FAIL ferr_con: got %08h expected 00000042", d); end
    bus_read(A_CON, d);
    total++; if (d !== 32'h02) begin bad++; $display("FAIL ferr_clear: got %08h expected 00000002", d); end
    bus_read(A_RXD, d);
    total++; if (d !== {24'd0, rx_last}) begin bad++; $display("FAIL ferr_data_kept: got %08h expected %08h", d, {24'd0, rx_last}); end
    @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (4*BD) @(negedge clk);
    bus_read(A_CON, d);
    total++; if (d !== 32'h02) begin bad++; $display("FAIL glitch_con: got %08h expected 00000002", d); end
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL glitch_irq: got %b expected 0", irq); end
    $display("errors: framing error flagged, glitch ignored, con=%08h", d);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(A_TXD, 32'h55);
    repeat (3*BD) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL mid_reset_tx: got %b expected 1", uart_tx); end
    repeat (2*BD) @(negedge clk);
    reset = 1'b1;
    bus_read(A_CON, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL mid_reset_con: got %08h expected 0", d); end
    bus_read(A_RXD, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL mid_reset_rxd: got %08h expected 0", d); end
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL mid_reset_idle: got %b expected 1", uart_tx); end
    bus_write(A_CON, 32'h2);
    send_frame(8'h7E, 1'b1);
    repeat (2) @(negedge clk);
    supervisor = 1'b1;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL sup_mask: got %b expected 0", irq); end
    supervisor = 1'b0;
    #1;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL sup_unmask: got %b expected 1", irq); end
    bus_read(A_RXD, d);
    rx_last = rx_exp.pop_front();
    total++; if (d !== {24'd0, rx_last}) begin bad++; $display("FAIL post_reset_rx: got %08h expected %08h", d, {24'd0, rx_last}); end
    repeat (12*BD) @(negedge clk);
    total++; if (tx_exp.size() != 0) begin bad++; $display("FAIL tx_pending: got %0d frames outstanding expected 0", tx_exp.size()); end
    $display("reset_mid: frame aborted, rx after reset %02h", d[7:0]);
  endtask

  initial begin
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
    #1;
    test_reset();
    test_tx();
    test_rx();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_ctrl.md
UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 5208, meaning clk cycles per UART bit (50 MHz / 9600 baud); legal range 4..65535.
REQ-002 SHALL have port clk, input, 1 bit: system clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rd, input, 1 bit: bus read strobe from MEM stage.
REQ-005 SHALL have port wr, input, 1 bit: bus write strobe from MEM stage.
REQ-006 SHALL have port addr, input, 32 bits: byte address from MEM stage ALU result.
REQ-007 SHALL have port wdata, input, 32 bits: store data.
REQ-008 SHALL have port rdata, output, 32 bits: load data, combinational.
REQ-009 SHALL have port uart_rx, input, 1 bit: asynchronous serial input, idle high.
REQ-010 SHALL have port uart_tx, output, 1 bit: serial output, idle high.
REQ-011 SHALL have port supervisor, input, 1 bit: PC[31] of the MEM-stage instruction; 1 masks irq.
REQ-012 SHALL have port irq, output, 1 bit: interrupt request to Control, level.

Function
REQ-013 SHALL decode full 32-bit addresses: 0x40000018 TXD (W), 0x4000001C RXD (R), 0x40000020 CON (R/W); all other addresses are ignored on write and return 0 on read.
REQ-014 SHALL drive rdata = 0 when rd=0; RXD reads {24'b0, rx_data}; CON reads {25'b0, ferr, ovr, tx_busy, tx_done, rx_ready, rx_ie, tx_ie}.
REQ-015 SHALL make CON writes affect only tx_ie (bit0) and rx_ie (bit1); bits 6..2 are read-only.
REQ-016 SHALL clear tx_done, ovr and ferr on the rising edge that completes a CON read (rd=1), and clear rx_ready on the edge that completes an RXD read.
REQ-017 SHALL, on a TXD write while tx_busy=0, latch wdata[7:0] and set tx_busy on that edge; a TXD write while tx_busy=1 is discarded with no state change.
REQ-018 SHALL use TX states IDLE, START, DATA, STOP; each bit lasts exactly BAUD_DIV cycles; START drives 0, DATA drives 8 bits LSB first, STOP drives 1.
REQ-019 SHALL make uart_tx fall on the first clk edge after the accepting TXD write edge, and clear tx_busy and set tx_done exactly 10*BAUD_DIV cycles after uart_tx falls.
REQ-020 SHALL register uart_tx (glitch-free output) and hold it at 1 in IDLE.
REQ-021 SHALL pass uart_rx through a two-flop synchronizer before any use.
REQ-022 SHALL use RX states IDLE, START, DATA, STOP; IDLE leaves on a synchronized 1->0 edge.
REQ-023 SHALL, in START, resample after BAUD_DIV/2 cycles (integer division); if high return to IDLE (false start, no flag), else sample 8 data bits at BAUD_DIV intervals, LSB first.
REQ-024 SHALL sample the stop bit BAUD_DIV cycles after data bit 7: if 1, load rx_data and set rx_ready (setting ovr if rx_ready was already 1 and not being cleared on that edge); if 0, discard the byte, set ferr, leave rx_data unchanged.
REQ-025 SHALL, when a byte completes on the same edge as an RXD read, load the new byte and leave rx_ready = 1, without setting ovr.
REQ-026 SHALL let a flag set and a clearing CON read on the same edge resolve to set.
REQ-027 SHALL return the RX FSM to IDLE directly after the stop sample, ready for back-to-back frames.
REQ-028 SHALL drive irq = ~supervisor & ((tx_ie & tx_done) | (rx_ie & rx_ready)), combinational from registered state.
REQ-029 SHALL operate TX and RX fully independently, so full-duplex operation and loopback are legal.

Reset
REQ-030 SHALL, with reset=0, asynchronously force both FSMs to IDLE, all counters and shift registers to 0, rx_data=0, all CON bits to 0, and uart_tx=1.
REQ-031 SHALL abort a frame in progress when reset is asserted mid-frame; after release, TX idles high and RX waits for a fresh falling edge.

Verification (BAUD_DIV=4)
REQ-032 SHALL pass: write TXD=0x000000A5 -> uart_tx = 0,1,0,1,0,0,1,0,1,1, each 4 cycles; tx_busy=1 for 40 cycles; then tx_done=1.
REQ-033 SHALL pass: drive uart_rx frame 0x3C -> RXD reads 0x3C, rx_ready=1; with rx_ie=1 and supervisor=0 -> irq=1; RXD read -> irq=0.
REQ-034 SHALL pass: second TXD write 0x11 during the 0xA5 frame -> discarded, only 0xA5 transmitted.
REQ-035 SHALL pass: two RX frames 0x01, 0x02 without a read -> RXD=0x02, CON bit5 (ovr)=1; CON read clears ovr.
REQ-036 SHALL pass: RX frame with stop bit 0 -> ferr=1, rx_ready=0; a 1-cycle low glitch on uart_rx -> no flag set.
REQ-037 SHALL pass: reset asserted mid TX frame -> uart_tx=1 immediately, CON reads 0; supervisor=1 with a pending flag -> irq=0.
